// File: rtl/spi_s_if.sv
// SPI responder bundle: serial pins toward the initiator plus the local word interface.
// Latency: none, wires only.
// Backpressure: none; rx_valid and frame_err are single-cycle strobes with no ready.
//
// Ports:
//   sclk/cs_n/mosi : SPI pins driven by the initiator.
//   miso/miso_oe   : SPI return data and its pad enable.
//   tx_data/tx_load: word to return in a later frame, captured on tx_load.
//   rx_data/rx_valid/frame_err/busy : received word, its strobe, abort strobe, activity flag.
interface spi_s_if #(
  parameter int DATA_W = 32
);
  logic              sclk;
  logic              cs_n;
  logic              mosi;
  logic              miso;
  logic              miso_oe;
  logic [DATA_W-1:0] tx_data;
  logic              tx_load;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              frame_err;
  logic              busy;

  // Responder side (the spi_s block).
  modport slave (
    input  sclk, cs_n, mosi, tx_data, tx_load,
    output miso, miso_oe, rx_data, rx_valid, frame_err, busy
  );

  // Initiator plus local-logic side.
  modport master (
    output sclk, cs_n, mosi, tx_data, tx_load,
    input  miso, miso_oe, rx_data, rx_valid, frame_err, busy
  );
endinterface

// File: rtl/spi_s.sv
// SPI mode-0 responder, MSB-first DATA_W-bit frames, all pins oversampled on clk.
// Latency: rx_valid rises SYNC_STAGES+2 clk edges after the last sclk rise reaches the synchronizer.
// Backpressure: none; the received word is strobed once and local logic must take it.
//
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset.
//   bus        : spi_s_if.slave (SPI pins, tx_data/tx_load, rx_data/rx_valid, frame_err, busy).
module spi_s #(
  parameter int DATA_W      = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic   clk,
  input  logic   rst_n,
  spi_s_if.slave bus
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic                   sclk_hist, cs_hist;
  logic                   sclk_s, cs_s, mosi_s;
  logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;

  logic [DATA_W-1:0] tx_buf;
  logic [DATA_W-1:0] tx_shift;
  logic [DATA_W-1:0] rx_shift;
  logic [DATA_W-1:0] rx_data;
  logic [CNT_W-1:0]  bit_cnt;
  logic              rx_valid;
  logic              frame_err;
  logic              miso_oe;
  logic              miso;
  logic              busy;

  // Synchronizers plus one history flop for edge detection. cs_n resets
  // to its idle (high) level so reset release never looks like a cs_fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_hist <= 1'b0;
      cs_hist   <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi};
      sclk_hist <= sclk_s;
      cs_hist   <= cs_s;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise =  sclk_s & ~sclk_hist;
  assign sclk_fall = ~sclk_s &  sclk_hist;
  assign cs_rise   =  cs_s   & ~cs_hist;
  assign cs_fall   = ~cs_s   &  cs_hist;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic. A full count wins over a coincident cs_rise so a
  // complete word is still delivered.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cs_fall) state_nxt = SHIFT;
      SHIFT: begin
        if (bit_cnt == CNT_FULL) state_nxt = cs_rise ? IDLE : DONE;
        else if (cs_rise)        state_nxt = IDLE;
      end
      DONE:    if (cs_rise) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic. miso is forced low outside SHIFT so DONE returns zeros.
  always_comb begin
    busy = (state != IDLE);
    miso = (state == SHIFT) ? tx_shift[DATA_W-1] : 1'b0;
  end

  // Datapath. tx_buf is independent of the frame so a load mid-frame only
  // affects the next frame; a load coinciding with cs_fall is likewise deferred.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_buf    <= '0;
      tx_shift  <= '0;
      rx_shift  <= '0;
      rx_data   <= '0;
      bit_cnt   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      miso_oe   <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      if (bus.tx_load) tx_buf <= bus.tx_data;

      case (state)
        IDLE: begin
          if (cs_fall) begin
            tx_shift <= tx_buf;
            bit_cnt  <= '0;
            miso_oe  <= 1'b1;
          end
        end
        SHIFT: begin
          if (bit_cnt == CNT_FULL) begin
            rx_data  <= rx_shift;
            rx_valid <= 1'b1;
            if (cs_rise) miso_oe <= 1'b0;
          end else if (cs_rise) begin
            // Release before the first bit is a silent cancel.
            miso_oe <= 1'b0;
            if (bit_cnt != '0) frame_err <= 1'b1;
          end else if (sclk_rise) begin
            rx_shift <= {rx_shift[DATA_W-2:0], mosi_s};
            bit_cnt  <= bit_cnt + CNT_W'(1);
          end else if (sclk_fall && (bit_cnt != '0)) begin
            // No shift on a stray fall before the first rise.
            tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
          end
        end
        DONE: begin
          if (cs_rise) miso_oe <= 1'b0;
        end
        default: miso_oe <= 1'b0;
      endcase
    end
  end

  assign bus.miso      = miso;
  assign bus.miso_oe   = miso_oe;
  assign bus.rx_data   = rx_data;
  assign bus.rx_valid  = rx_valid;
  assign bus.frame_err = frame_err;
  assign bus.busy      = busy;

endmodule

// File: tb/tb_spi_s.sv
// Directed bench for spi_s acting as the SPI initiator and local logic.
// Latency: sclk runs at clk/10; every wait is a fixed cycle count.
// Backpressure: none; strobes are counted by a monitor on the falling clk edge.
module tb_spi_s;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   rx_cnt;
  int   err_cnt;

  spi_s_if #(.DATA_W(32)) bus ();

  spi_s #(.DATA_W(32), .SYNC_STAGES(2)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.rx_valid === 1'b1)  rx_cnt  = rx_cnt + 1;
    if (bus.frame_err === 1'b1) err_cnt = err_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      failures = failures + 1;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One cs_n window: nbits sclk pulses sending mo[nbits-1:0] MSB first.
  // miso is sampled just before each rising sclk. Optionally pulses tx_load
  // before bit load_at, and optionally leaves cs_n low at the end.
  task automatic spi_xfer(input logic [63:0] mo, input int nbits, input bit release_cs,
                          input int load_at, input logic [31:0] load_val,
                          output logic [31:0] mi, output logic extra_or,
                          output logic busy_end, output logic oe_end);
    mi = '0;
    extra_or = 1'b0;
    bus.cs_n = 1'b0;
    tick(5);
    for (int i = 0; i < nbits; i++) begin
      if (i == load_at) begin
        bus.tx_data = load_val;
        bus.tx_load = 1'b1;
        tick(1);
        bus.tx_load = 1'b0;
      end
      bus.mosi = mo[nbits-1-i];
      tick(5);
      if (i < 32) mi = {mi[30:0], bus.miso};
      else        extra_or = extra_or | bus.miso;
      bus.sclk = 1'b1;
      tick(5);
      bus.sclk = 1'b0;
    end
    tick(5);
    busy_end = bus.busy;
    oe_end   = bus.miso_oe;
    if (release_cs) begin
      bus.cs_n = 1'b1;
      tick(10);
    end
  endtask

  initial begin
    logic [31:0] mi;
    logic        extra_or, busy_end, oe_end;
    int          rx0, err0;

    checks = 0; failures = 0; rx_cnt = 0; err_cnt = 0;
    rst_n = 1'b0;
    bus.sclk = 1'b0; bus.cs_n = 1'b1; bus.mosi = 1'b0;
    bus.tx_data = '0; bus.tx_load = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(3);

    // Reset values.
    check("rst_miso",      32'(bus.miso),      32'd0);
    check("rst_miso_oe",   32'(bus.miso_oe),   32'd0);
    check("rst_rx_data",   bus.rx_data,        32'd0);
    check("rst_rx_valid",  32'(bus.rx_valid),  32'd0);
    check("rst_frame_err", 32'(bus.frame_err), 32'd0);
    check("rst_busy",      32'(bus.busy),      32'd0);

    // Basic frame.
    bus.tx_data = 32'hA5A5_1234; bus.tx_load = 1'b1; tick(1); bus.tx_load = 1'b0;
    tick(2);
    rx0 = rx_cnt;
    spi_xfer({32'd0, 32'hDEAD_BEEF}, 32, 1'b1, -1, '0, mi, extra_or, busy_end, oe_end);
    check("f1_miso",      mi,                32'hA5A5_1234);
    check("f1_rx_data",   bus.rx_data,       32'hDEAD_BEEF);
    check("f1_rx_valids", 32'(rx_cnt - rx0), 32'd1);
    check("f1_busy_in",   32'(busy_end),     32'd1);
    check("f1_busy_out",  32'(bus.busy),     32'd0);
    check("f1_oe_out",    32'(bus.miso_oe),  32'd0);

    // Back-to-back frames re-send the same buffer.
    rx0 = rx_cnt;
    spi_xfer({32'd0, 32'h0F0F_0F0F}, 32, 1'b1, -1, '0, mi, extra_or, busy_end, oe_end);
    check("f2_miso", mi, 32'hA5A5_1234);
    spi_xfer({32'd0, 32'h0000_0001}, 32, 1'b1, -1, '0, mi, extra_or, busy_end, oe_end);
    check("f3_miso",      mi,                32'hA5A5_1234);
    check("f3_rx_data",   bus.rx_data,       32'h0000_0001);
    check("f3_rx_valids", 32'(rx_cnt - rx0), 32'd2);

    // Early release after 17 bits.
    rx0 = rx_cnt; err0 = err_cnt;
    spi_xfer({32'd0, 32'hFFFF_FFFF}, 17, 1'b1, -1, '0, mi, extra_or, busy_end, oe_end);
    check("er_frame_errs", 32'(err_cnt - err0), 32'd1);
    check("er_rx_valids",  32'(rx_cnt - rx0),   32'd0);
    check("er_rx_data",    bus.rx_data,         32'h0000_0001);
    check("er_oe",         32'(bus.miso_oe),    32'd0);
    check("er_busy",       32'(bus.busy),       32'd0);

    // 40 pulses: extra edges ignored, miso low in DONE.
    rx0 = rx_cnt; err0 = err_cnt;
    spi_xfer({24'd0, 32'h1234_5678, 8'hFF}, 40, 1'b1, -1, '0, mi, extra_or, busy_end, oe_end);
    check("ov_miso",       mi,                  32'hA5A5_1234);
    check("ov_rx_data",    bus.rx_data,         32'h1234_5678);
    check("ov_rx_valids",  32'(rx_cnt - rx0),   32'd1);
    check("ov_done_miso",  32'(extra_or),       32'd0);
    check("ov_done_oe",    32'(oe_end),         32'd1);
    check("ov_done_busy",  32'(busy_end),       32'd1);
    check("ov_frame_errs", 32'(err_cnt - err0), 32'd0);

    // tx_load mid-frame takes effect on the following frame.
    spi_xfer({32'd0, 32'h0000_0000}, 32, 1'b1, 10, 32'h5555_AAAA, mi, extra_or, busy_end, oe_end);
    check("ld_cur_miso", mi, 32'hA5A5_1234);
    spi_xfer({32'd0, 32'h0000_0000}, 32, 1'b1, -1, '0, mi, extra_or, busy_end, oe_end);
    check("ld_next_miso", mi, 32'h5555_AAAA);

    // Asynchronous reset after bit 20.
    rx0 = rx_cnt; err0 = err_cnt;
    spi_xfer({32'd0, 32'hFFFF_FFFF}, 20, 1'b0, -1, '0, mi, extra_or, busy_end, oe_end);
    rst_n = 1'b0;
    #1;
    check("ar_miso",      32'(bus.miso),      32'd0);
    check("ar_miso_oe",   32'(bus.miso_oe),   32'd0);
    check("ar_rx_data",   bus.rx_data,        32'd0);
    check("ar_rx_valid",  32'(bus.rx_valid),  32'd0);
    check("ar_frame_err", 32'(bus.frame_err), 32'd0);
    check("ar_busy",      32'(bus.busy),      32'd0);
    tick(1);
    bus.cs_n = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(10);
    check("ar_rx_valids",  32'(rx_cnt - rx0),   32'd0);
    check("ar_frame_errs", 32'(err_cnt - err0), 32'd0);

    // Normal frame after reset.
    rx0 = rx_cnt;
    bus.tx_data = 32'h1357_9BDF; bus.tx_load = 1'b1; tick(1); bus.tx_load = 1'b0;
    tick(2);
    spi_xfer({32'd0, 32'h2468_ACE0}, 32, 1'b1, -1, '0, mi, extra_or, busy_end, oe_end);
    check("pr_miso",      mi,                32'h1357_9BDF);
    check("pr_rx_data",   bus.rx_data,       32'h2468_ACE0);
    check("pr_rx_valids", 32'(rx_cnt - rx0), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
